cpu_axi_bridge: RTL and testbench

- Converts the CPU core's two SRAM-like ports (inst, data) into one AXI3 master port for the SoC interconnect.
- Sits directly downstream of the CPU top; that top's inst_sram_*/data_sram_* outputs connect here.
- Supports one outstanding read per source and one outstanding write (data side only).

---
 rtl/cpu_axi_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: CPU inst/data SRAM-like ports onto one AXI3 master.
// Optional BRIDGE_EARLY_WRESP_EN: write data_ok after AW+W, B tracked separately.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic        live;
  logic [1:0]  i_rs, d_rs, ws;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  i_size, d_size;
  logic [3:0]  d_wstrb;
  logic        i_ok, d_rok, d_wok;
  logic        aw_done, w_done;
  logic        ar_hold, ar_own, ar_sel;
  logic        i_acc, d_acc, i_haz, d_haz;
  logic        ar_hs, aw_hs, w_hs, w_fin, wr_done;
  logic        i_rhs, d_rhs;
  logic [1:0]  w_next;
  logic        unused_in;

  assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rresp, rlast, bid, bresp};

  assign w_fin = ws == W_SEND && (aw_done || aw_hs) && (w_done || w_hs);

`ifdef BRIDGE_EARLY_WRESP_EN
  logic        wr_pending;
  logic [29:0] pend_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_pending <= 1'b0;
      pend_addr  <= '0;
    end else if (w_fin) begin
      wr_pending <= 1'b1;
      pend_addr  <= d_addr[31:2];
    end else if (bvalid) begin
      wr_pending <= 1'b0;
    end
  end

  // only a read to the word still awaiting B must wait
  assign i_haz   = ws != W_IDLE ||
                   (wr_pending && inst_sram_addr[31:2] == pend_addr);
  assign d_haz   = ws != W_IDLE ||
                   (wr_pending && (data_sram_wr ||
                    data_sram_addr[31:2] == pend_addr));
  assign wr_done = w_fin;
  assign w_next  = W_IDLE;
`else
  assign i_haz   = ws != W_IDLE;
  assign d_haz   = ws != W_IDLE;
  assign wr_done = ws == W_RESP && bvalid;
  assign w_next  = W_RESP;
`endif

  assign i_acc = live && inst_sram_req && i_rs == R_IDLE && !i_haz;
  assign d_acc = live && data_sram_req && d_rs == R_IDLE && !d_haz;
  assign inst_sram_addr_ok = i_acc;
  assign data_sram_addr_ok = d_acc;
  assign inst_sram_data_ok = i_ok;
  assign data_sram_data_ok = d_rok || d_wok;

  // an AR already presented keeps its owner until accepted
  assign ar_sel  = ar_hold ? ar_own : (d_rs == R_AR);
  assign arvalid = i_rs == R_AR || d_rs == R_AR;
  assign arid    = ar_sel ? DATA_ID : INST_ID;
  assign araddr  = ar_sel ? d_addr : i_addr;
  assign arsize  = {1'b0, ar_sel ? d_size : i_size};
  assign ar_hs   = arvalid && arready;
  assign i_rhs   = rvalid && rid == INST_ID && i_rs == R_WAIT;
  assign d_rhs   = rvalid && rid == DATA_ID && d_rs == R_WAIT;

  assign awid    = DATA_ID;
  assign wid     = DATA_ID;
  assign awaddr  = d_addr;
  assign awsize  = {1'b0, d_size};
  assign wdata   = d_wdata;
  assign wstrb   = d_wstrb;
  assign wlast   = 1'b1;
  assign awvalid = ws == W_SEND && !aw_done;
  assign wvalid  = ws == W_SEND && !w_done;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign rready  = live;
  assign bready  = live;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live    <= 1'b0;
      i_addr  <= '0;
      i_size  <= '0;
      d_addr  <= '0;
      d_size  <= '0;
      d_wdata <= '0;
      d_wstrb <= '0;
      ar_hold <= 1'b0;
      ar_own  <= 1'b0;
    end else begin
      live    <= 1'b1;
      ar_hold <= arvalid && !arready;
      ar_own  <= ar_sel;
      if (i_acc) begin
        i_addr <= inst_sram_addr;
        i_size <= inst_sram_size;
      end
      if (d_acc) begin
        d_addr  <= data_sram_addr;
        d_size  <= data_sram_size;
        d_wdata <= data_sram_wdata;
        d_wstrb <= data_sram_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rs            <= R_IDLE;
      d_rs            <= R_IDLE;
      i_ok            <= 1'b0;
      d_rok           <= 1'b0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      i_ok  <= i_rhs;
      d_rok <= d_rhs;
      if (i_rhs) inst_sram_rdata <= rdata;
      if (d_rhs) data_sram_rdata <= rdata;
      case (i_rs)
        R_IDLE:  if (i_acc) i_rs <= R_AR;
        R_AR:    if (ar_hs && !ar_sel) i_rs <= R_WAIT;
        R_WAIT:  if (i_rhs) i_rs <= R_IDLE;
        default: i_rs <= R_IDLE;
      endcase
      case (d_rs)
        R_IDLE:  if (d_acc && !data_sram_wr) d_rs <= R_AR;
        R_AR:    if (ar_hs && ar_sel) d_rs <= R_WAIT;
        R_WAIT:  if (d_rhs) d_rs <= R_IDLE;
        default: d_rs <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws      <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      d_wok   <= 1'b0;
    end else begin
      d_wok <= wr_done;
      case (ws)
        W_IDLE: if (d_acc && data_sram_wr) begin
          ws      <= W_SEND;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        W_SEND: begin
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if (w_fin) ws <= w_next;
        end
        W_RESP:  if (bvalid) ws <= W_IDLE;
        default: ws <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed AXI stimulus with a data_ok scoreboard.
// Build with +define+BRIDGE_EARLY_WRESP_EN to cover the early write response.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid, awid, wid, bid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;

  typedef struct {
    logic        wr;
    logic [31:0] d;
  } dexp_t;

  logic [31:0] iq[$];
  dexp_t       dq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          i_ok_cnt = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 20) begin
      nxt();
      n++;
    end
    if (iq.size() != 0 || dq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout got=%0d/%0d pending exp=0",
               iq.size(), dq.size());
      iq.delete();
      dq.delete();
    end
    repeat (3) nxt();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (inst_sram_data_ok) begin
        i_ok_cnt++;
        if (iq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL inst_unexpected_ok got=%h exp=none",
                   inst_sram_rdata);
        end else begin
          chk("inst_rdata", inst_sram_rdata, iq.pop_front());
        end
      end
      if (data_sram_data_ok) begin
        if (dq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL data_unexpected_ok got=%h exp=none",
                   data_sram_rdata);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          if (!e.wr) chk("data_rdata", data_sram_rdata, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0;
    inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0;
    data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 1; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    nxt();
    resetn = 1'b1;
    nxt();
    @(negedge clk);
    chk("post_rst_rready", rready, 1);
    chk("post_rst_bready", bready, 1);

    // single instruction fetch, best latency
    nxt();
    inst_sram_req = 1; inst_sram_addr = 32'hBFC00000; inst_sram_size = 2;
    @(negedge clk);
    chk("t1_addr_ok", inst_sram_addr_ok, 1);
    iq.push_back(32'h3C1D0000);
    nxt(); inst_sram_req = 0;
    @(negedge clk);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'hBFC00000);
    chk("t1_arid", arid, 0);
    chk("t1_arsize", arsize, 3'b010);
    nxt(); rvalid = 1; rid = 0; rdata = 32'h3C1D0000;
    nxt(); rvalid = 0;
    drain();

    // simultaneous requests, data wins AR, responses out of order
    inst_sram_req = 1; inst_sram_addr = 32'hBFC00100;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h80000000;
    data_sram_size = 2;
    @(negedge clk);
    chk("t2_inst_addr_ok", inst_sram_addr_ok, 1);
    chk("t2_data_addr_ok", data_sram_addr_ok, 1);
    iq.push_back(32'h11111111);
    dq.push_back('{wr: 1'b0, d: 32'h22222222});
    nxt(); inst_sram_req = 0; data_sram_req = 0;
    @(negedge clk);
    chk("t2_ar1_id", arid, 1);
    chk("t2_ar1_addr", araddr, 32'h80000000);
    nxt();
    @(negedge clk);
    chk("t2_ar2_valid", arvalid, 1);
    chk("t2_ar2_id", arid, 0);
    chk("t2_ar2_addr", araddr, 32'hBFC00100);
    nxt(); rvalid = 1; rid = 0; rdata = 32'h11111111;
    nxt(); rid = 1; rdata = 32'h22222222;
    nxt(); rvalid = 0;
    drain();

    // write with split AW/W handshakes, reads blocked meanwhile
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h80000010;
    data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'b0011;
    data_sram_size = 2;
    @(negedge clk);
    chk("t3_addr_ok", data_sram_addr_ok, 1);
    dq.push_back('{wr: 1'b1, d: 32'h0});
    nxt(); data_sram_req = 0; data_sram_wr = 0; awready = 1;
    inst_sram_req = 1; inst_sram_addr = 32'hBFC00200;
    @(negedge clk);
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h80000010);
    chk("t3_wdata", wdata, 32'h12345678);
    chk("t3_wstrb", wstrb, 4'b0011);
    chk("t3_awid", awid, 1);
    chk("t3_wid", wid, 1);
    chk("t3_wlast", wlast, 1);
    chk("t3_awsize", awsize, 3'b010);
    chk("t3_inst_blk1", inst_sram_addr_ok, 0);
    nxt(); awready = 0;
    @(negedge clk);
    chk("t3_aw_dropped", awvalid, 0);
    chk("t3_w_held", wvalid, 1);
    chk("t3_inst_blk2", inst_sram_addr_ok, 0);
    nxt(); wready = 1;
    @(negedge clk);
    chk("t3_w_held3", wvalid, 1);
    chk("t3_inst_blk3", inst_sram_addr_ok, 0);
    nxt(); wready = 0; inst_sram_req = 0;
    @(negedge clk);
    chk("t3_w_dropped", wvalid, 0);
`ifndef BRIDGE_EARLY_WRESP_EN
    inst_sram_req = 1;
    @(negedge clk);
    chk("t3_inst_blk4", inst_sram_addr_ok, 0);
    chk("t3_no_early_ok", data_sram_data_ok, 0);
    nxt(); bvalid = 1;
    @(negedge clk);
    chk("t3_inst_blk5", inst_sram_addr_ok, 0);
    chk("t3_ok_after_b", data_sram_data_ok, 0);
    nxt(); bvalid = 0; inst_sram_req = 0;
    @(negedge clk);
    chk("t3_ok_pulse", data_sram_data_ok, 1);
`else
    chk("t3_early_ok", data_sram_data_ok, 1);
    nxt(); bvalid = 1;
    nxt(); bvalid = 0;
`endif
    drain();

    // AR back-pressure: fields stable, one response
    arready = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h80000042;
    data_sram_size = 1;
    @(negedge clk);
    chk("t4_addr_ok", data_sram_addr_ok, 1);
    dq.push_back('{wr: 1'b0, d: 32'hCAFEF00D});
    nxt(); data_sram_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_arvalid", arvalid, 1);
      chk("t4_araddr", araddr, 32'h80000042);
      chk("t4_arid", arid, 1);
      chk("t4_arsize", arsize, 3'b001);
      nxt();
    end
    arready = 1;
    @(negedge clk);
    chk("t4_arvalid_hs", arvalid, 1);
    nxt(); rvalid = 1; rid = 1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t4_ar_done", arvalid, 0);
    nxt(); rvalid = 0;
    drain();

    // write then read of the same word waits for B
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00000100;
    data_sram_wdata = 32'hA5A5A5A5; data_sram_wstrb = 4'hF;
    data_sram_size = 2; awready = 1; wready = 1;
    @(negedge clk);
    chk("t5_wr_addr_ok", data_sram_addr_ok, 1);
    dq.push_back('{wr: 1'b1, d: 32'h0});
    nxt(); data_sram_req = 0; data_sram_wr = 0;
    nxt(); data_sram_req = 1; data_sram_addr = 32'h00000100;
    @(negedge clk);
    chk("t5_rd_blk1", data_sram_addr_ok, 0);
    nxt(); bvalid = 1;
    @(negedge clk);
    chk("t5_rd_blk2", data_sram_addr_ok, 0);
    nxt(); bvalid = 0;
    @(negedge clk);
    chk("t5_rd_ok", data_sram_addr_ok, 1);
    dq.push_back('{wr: 1'b0, d: 32'h66666666});
    nxt(); data_sram_req = 0;
    nxt(); rvalid = 1; rid = 1; rdata = 32'h66666666;
    nxt(); rvalid = 0;
    drain();

`ifdef BRIDGE_EARLY_WRESP_EN
    // write then read of another word proceeds before B
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00000100;
    @(negedge clk);
    chk("t6_wr_addr_ok", data_sram_addr_ok, 1);
    dq.push_back('{wr: 1'b1, d: 32'h0});
    nxt(); data_sram_req = 0; data_sram_wr = 0;
    nxt(); data_sram_req = 1; data_sram_addr = 32'h00000104;
    dq.push_back('{wr: 1'b0, d: 32'h55AA55AA});
    @(negedge clk);
    chk("t6_rd_addr_ok", data_sram_addr_ok, 1);
    chk("t6_wr_ok", data_sram_data_ok, 1);
    nxt(); data_sram_req = 0;
    nxt(); rvalid = 1; rid = 1; rdata = 32'h55AA55AA;
    nxt(); rvalid = 0; bvalid = 1;
    nxt(); bvalid = 0;
    drain();
`endif
    awready = 0; wready = 0;

    // reset in the middle of an outstanding read
    inst_sram_req = 1; inst_sram_addr = 32'hBFC00300;
    @(negedge clk);
    chk("t7_addr_ok", inst_sram_addr_ok, 1);
    nxt(); inst_sram_req = 0;
    nxt();
    resetn = 0;
    #1;
    chk("t7_arvalid", arvalid, 0);
    chk("t7_inst_ok", inst_sram_data_ok, 0);
    chk("t7_rready", rready, 0);
    chk("t7_bready", bready, 0);
    chk("t7_inst_rdata", inst_sram_rdata, 0);
    chk("t7_data_rdata", data_sram_rdata, 0);
    nxt(); resetn = 1;
    c0 = i_ok_cnt;
    nxt(); rvalid = 1; rid = 0; rdata = 32'hDEAD0000;
    nxt(); rvalid = 0;
    repeat (3) nxt();
    @(negedge clk);
    chk("t7_no_late_ok", i_ok_cnt, c0);
    chk("t7_rready_back", rready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
